// File: rtl/cnn_pkg.sv
// Shared definitions for the keyword-spotting CNN stages: default activation
// width, pooling FSM state encoding and the pooled-width helper.
package cnn_pkg;

   localparam int ACTIV_BITS_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      POOL = 1'b1
   } state_t;

   // Number of full windows that fit in a row; trailing positions are dropped.
   function automatic int calc_out_width(input int width, input int pool, input int stride);
      return (width - pool) / stride + 1;
   endfunction

endpackage

// File: rtl/maxpool_window.sv
// Combinational maximum of POOL_SIZE activation lanes.
// Build option: MAXPOOL1D_SIGNED_EN selects two's-complement comparison;
// without it lanes are compared as unsigned (post-ReLU) values.
module maxpool_window #(
   parameter int POOL_SIZE  = 2,
   parameter int ACTIV_BITS = 16
) (
   input  logic [POOL_SIZE*ACTIV_BITS-1:0] lanes,
   output logic [ACTIV_BITS-1:0]           max_val
);

   // Linear scan; only a strictly larger lane replaces the running max, so ties keep the value.
   always_comb begin
      max_val = lanes[0 +: ACTIV_BITS];
      for (int i = 1; i < POOL_SIZE; i++) begin
`ifdef MAXPOOL1D_SIGNED_EN
         if ($signed(lanes[i*ACTIV_BITS +: ACTIV_BITS]) > $signed(max_val))
            max_val = lanes[i*ACTIV_BITS +: ACTIV_BITS];
`else
         if (lanes[i*ACTIV_BITS +: ACTIV_BITS] > max_val)
            max_val = lanes[i*ACTIV_BITS +: ACTIV_BITS];
`endif
      end
   end

endmodule

// File: rtl/maxpool1d.sv
// 1-D max pooling along the width axis, one window per clock, all filters in
// parallel. The pooled frame is published atomically with a one-cycle pulse.
// Build option: MAXPOOL1D_SIGNED_EN (signed activation compare, see maxpool_window).
//
// state | meaning
// IDLE  | ready for a frame; data_valid captures data_in
// POOL  | one window per edge into the result buffer; data_valid sets overrun
module maxpool1d
   import cnn_pkg::*;
#(
   parameter int INPUT_WIDTH = 40,
   parameter int NUM_FILTERS = 8,
   parameter int POOL_SIZE   = 2,
   parameter int STRIDE      = 2,
   parameter int ACTIV_BITS  = ACTIV_BITS_DEF,
   localparam int OUT_WIDTH  = calc_out_width(INPUT_WIDTH, POOL_SIZE, STRIDE)
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [INPUT_WIDTH*NUM_FILTERS*ACTIV_BITS-1:0] data_in,
   input  logic                                       data_valid,
   output logic                                       data_ready,
   output logic [OUT_WIDTH*NUM_FILTERS*ACTIV_BITS-1:0]   data_out,
   output logic                                       data_out_valid,
   output logic                                       overrun
);

   localparam int IN_BITS  = INPUT_WIDTH * NUM_FILTERS * ACTIV_BITS;
   localparam int OUT_BITS = OUT_WIDTH * NUM_FILTERS * ACTIV_BITS;
   localparam int WIN_BITS = POOL_SIZE * ACTIV_BITS;
   localparam int CNT_W    = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

   state_t                                  state;
   logic [CNT_W-1:0]                        cnt;
   logic [IN_BITS-1:0]                      in_buf;
   logic [OUT_BITS-1:0]                     res_buf;
   logic [OUT_BITS-1:0]                     res_next;
   logic [NUM_FILTERS-1:0][WIN_BITS-1:0]    win_lanes;
   logic [NUM_FILTERS-1:0][ACTIV_BITS-1:0]  win_max;
   logic                                    last_win;

   assign data_ready = (state == IDLE);
   assign last_win   = (cnt == CNT_W'(OUT_WIDTH - 1));

   // Gather the current window (positions cnt*STRIDE ..) for each filter.
   always_comb begin
      win_lanes = '0;
      for (int k = 0; k < NUM_FILTERS; k++) begin
         for (int p = 0; p < POOL_SIZE; p++) begin
            win_lanes[k][p*ACTIV_BITS +: ACTIV_BITS] =
               in_buf[((int'(cnt)*STRIDE + p)*NUM_FILTERS + k)*ACTIV_BITS +: ACTIV_BITS];
         end
      end
   end

   for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_win
      maxpool_window #(
         .POOL_SIZE  (POOL_SIZE),
         .ACTIV_BITS (ACTIV_BITS)
      ) u_win (
         .lanes   (win_lanes[g]),
         .max_val (win_max[g])
      );
   end

   // Result buffer with this edge's window merged in, so the final window can be published in the same edge.
   always_comb begin
      res_next = res_buf;
      for (int k = 0; k < NUM_FILTERS; k++) begin
         res_next[(int'(cnt)*NUM_FILTERS + k)*ACTIV_BITS +: ACTIV_BITS] = win_max[k];
      end
   end

   // Sequencer: capture, per-window pooling, atomic publish and overrun tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         in_buf         <= '0;
         res_buf        <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         data_out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (data_valid) begin
                  in_buf <= data_in;
                  cnt    <= '0;
                  state  <= POOL;
               end
            end
            POOL: begin
               if (data_valid)
                  overrun <= 1'b1;
               res_buf <= res_next;
               if (last_win) begin
                  data_out       <= res_next;
                  data_out_valid <= 1'b1;
                  cnt            <= '0;
                  state          <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
